// File: rtl/ascon_feeder_pkg.sv
// rtl/ascon_feeder_pkg.sv - shared types and constants for the Ascon AXI4-Lite write feeder
// Contents: FSM state enum, AXI write-response codes, Ascon wrapper register map.
package ascon_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ASCON_BASE = 32'h0010_0000;
  localparam logic [31:0] OFS_NONCE  = 32'h0;
  localparam logic [31:0] OFS_AD     = 32'h1;
  localparam logic [31:0] OFS_PT     = 32'h2;
  localparam logic [31:0] OFS_KEY    = 32'h5;

endpackage

// File: rtl/ascon_feeder_fifo.sv
// rtl/ascon_feeder_fifo.sv - command FIFO for the Ascon AXI4-Lite write feeder
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request and word (ignored while full)
//   pop, pop_data      read request (ignored while empty); pop_data shows the head
//   full, empty        status from pointer state only
module ascon_feeder_fifo #(
  parameter int Depth = 4,
  parameter int Width = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [PtrW:0]      wr_ptr;
  logic [PtrW:0]      rd_ptr;
  logic [Width-1:0]   mem [Depth];
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PtrW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PtrW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]) && (wr_ptr[PtrW] != rd_ptr[PtrW]);

endmodule

// File: rtl/ascon_axil_feeder.sv
// rtl/ascon_axil_feeder.sv - queued AXI4-Lite write master feeding the Ascon wrapper
// Optional watchdog: define ASCON_FEEDER_TIMEOUT_EN.
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o, cmd_*_i       command push {addr, data, strb}
//   m_aw*, m_w*, m_b*                      AXI4-Lite write channels
//   busy_o                                 queue non-empty or write in flight
//   err_o, timeout_o, err_clr_i            sticky error/watchdog flags and their clear
//   wr_count_o                             completed B handshakes, wrapping
module ascon_axil_feeder
  import ascon_feeder_pkg::*;
#(
  parameter int FifoDepth     = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_data_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   m_awvalid_o,
  input  logic                   m_awready_i,
  output logic [AddrWidth-1:0]   m_awaddr_o,
  output logic [2:0]             m_awprot_o,
  output logic                   m_wvalid_o,
  input  logic                   m_wready_i,
  output logic [DataWidth-1:0]   m_wdata_o,
  output logic [DataWidth/8-1:0] m_wstrb_o,
  input  logic                   m_bvalid_i,
  output logic                   m_bready_o,
  input  logic [1:0]             m_bresp_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i,
  output logic                   timeout_o,
  output logic [15:0]            wr_count_o
);

  localparam int CmdWidth = AddrWidth + DataWidth + DataWidth / 8;

  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || TimeoutCycles < 1) begin : g_param_check
    $error("ascon_axil_feeder: FifoDepth must be a power of two >= 2 and TimeoutCycles >= 1");
  end

  state_e              state;
  logic                aw_done;
  logic                w_done;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [CmdWidth-1:0] fifo_head;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                both_done;
  logic                tmo_fire;

  ascon_feeder_fifo #(
    .Depth (FifoDepth),
    .Width (CmdWidth)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (cmd_valid_i),
    .push_data ({cmd_addr_i, cmd_data_i, cmd_strb_i}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready_o = !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign aw_hs       = m_awvalid_o && m_awready_i;
  assign w_hs        = m_wvalid_o && m_wready_i;
  assign b_hs        = m_bvalid_i && m_bready_o;
  // Done flags folded with this cycle's handshakes so AW and W finishing together count.
  assign both_done   = (aw_done || aw_hs) && (w_done || w_hs);
  assign m_awprot_o  = 3'b000;
  assign busy_o      = !fifo_empty || (state != IDLE);

`ifdef ASCON_FEEDER_TIMEOUT_EN
  localparam int TmrW = $clog2(TimeoutCycles + 1);
  logic [TmrW-1:0] timer;
  logic            leaving;
  logic            timeout_q;

  // A handshake that completes on the expiry cycle takes precedence over the watchdog.
  assign leaving  = ((state == ADDR) && both_done) || b_hs;
  assign tmo_fire = (state != IDLE) && !leaving && (timer == TmrW'(TimeoutCycles - 1));

  // Held at zero in IDLE and cleared on ADDR->RESP, so each busy state starts a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer <= '0;
    end else if ((state == IDLE) || leaving || tmo_fire) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (tmo_fire) begin
      timeout_q <= 1'b1;
    end else if (err_clr_i) begin
      timeout_q <= 1'b0;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if ((b_hs && (m_bresp_i != RESP_OKAY)) || tmo_fire) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      m_awaddr_o  <= '0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wr_count_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {m_awaddr_o, m_wdata_o, m_wstrb_o} <= fifo_head;
            m_awvalid_o <= 1'b1;
            m_wvalid_o  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (tmo_fire) begin
            m_awvalid_o <= 1'b0;
            m_wvalid_o  <= 1'b0;
            state       <= IDLE;
          end else begin
            if (aw_hs) begin
              m_awvalid_o <= 1'b0;
              aw_done     <= 1'b1;
            end
            if (w_hs) begin
              m_wvalid_o <= 1'b0;
              w_done     <= 1'b1;
            end
            if (both_done) begin
              m_bready_o <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            m_bready_o <= 1'b0;
            wr_count_o <= wr_count_o + 16'd1;
            state      <= IDLE;
          end else if (tmo_fire) begin
            m_bready_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_axil_feeder.sv
// tb/tb_ascon_axil_feeder.sv - self-checking bench for ascon_axil_feeder
module tb_ascon_axil_feeder;
  import ascon_feeder_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [2:0]  m_awprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic        busy, err, err_clr, timeout;
  logic [15:0] wr_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_count = 0;
  int stab_viol = 0;

  bit         aw_block = 0, w_block = 0, b_never = 0, rand_mode = 0;
  int         aw_stall = 0, w_stall = 0, b_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  cmd_t        exp_q[$];
  logic [31:0] aw_log[$];
  int          aw_cyc[$];
  logic [31:0] wd_log[$];
  logic [3:0]  ws_log[$];

  ascon_axil_feeder #(
    .FifoDepth     (4),
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .cmd_strb_i  (cmd_strb),
    .m_awvalid_o (m_awvalid),
    .m_awready_i (m_awready),
    .m_awaddr_o  (m_awaddr),
    .m_awprot_o  (m_awprot),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (m_wready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_bvalid_i  (m_bvalid),
    .m_bready_o  (m_bready),
    .m_bresp_i   (m_bresp),
    .busy_o      (busy),
    .err_o       (err),
    .err_clr_i   (err_clr),
    .timeout_o   (timeout),
    .wr_count_o  (wr_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // Slave model: ready/response a fixed distance after the master raises its signal.
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (m_awvalid) begin
        m_awready = rand_mode ? (aw_cnt >= 3 || $urandom_range(0, 1) == 1) : (!aw_block && aw_cnt >= aw_stall);
        aw_cnt++;
      end else begin
        m_awready = 0; aw_cnt = 0;
      end
      if (m_wvalid) begin
        m_wready = rand_mode ? (w_cnt >= 3 || $urandom_range(0, 1) == 1) : (!w_block && w_cnt >= w_stall);
        w_cnt++;
      end else begin
        m_wready = 0; w_cnt = 0;
      end
      if (m_bready) begin
        m_bvalid = !b_never && (rand_mode ? (b_cnt >= 3 || $urandom_range(0, 1) == 1) : (b_cnt >= b_delay));
        b_cnt++;
      end else begin
        m_bvalid = 0; b_cnt = 0;
      end
      m_bresp = bresp_cfg;
    end
  end

  // Bus monitor: logs handshakes and counts valid/payload instability before acceptance.
  initial begin
    logic        pend_aw, pend_w;
    logic [31:0] pa, pd;
    logic [3:0]  ps;
    pend_aw = 0; pend_w = 0; pa = 0; pd = 0; ps = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend_aw = 0; pend_w = 0;
      end else begin
        if (pend_aw && (!m_awvalid || m_awaddr !== pa)) stab_viol++;
        if (pend_w && (!m_wvalid || m_wdata !== pd || m_wstrb !== ps)) stab_viol++;
        if (m_awvalid && m_awready) begin aw_log.push_back(m_awaddr); aw_cyc.push_back(cyc); end
        if (m_wvalid && m_wready) begin wd_log.push_back(m_wdata); ws_log.push_back(m_wstrb); end
        pend_aw = m_awvalid && !m_awready; pa = m_awaddr;
        pend_w  = m_wvalid && !m_wready;   pd = m_wdata; ps = m_wstrb;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete(); aw_log.delete(); aw_cyc.delete(); wd_log.delete(); ws_log.delete();
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int tries, output bit acc);
    cmd_t c;
    cmd_valid = 1; cmd_addr = a; cmd_data = d; cmd_strb = s; acc = 0;
    for (int i = 0; i < tries && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 0;
    if (acc) begin
      c.addr = a; c.data = d; c.strb = s;
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_wr(input int target, input int budget);
    for (int i = 0; i < budget && wr_count != 16'(target); i++) step(1);
  endtask

  task automatic test_reset();
    rst_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0; err_clr = 0;
    step(3);
    rst_n = 1;
    step(1);
    n_vec++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid got %b want 0", m_awvalid); end
    n_vec++; if (m_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid got %b want 0", m_wvalid); end
    n_vec++; if (m_bready !== 1'b0) begin n_err++; $display("FAIL rst_bready got %b want 0", m_bready); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    n_vec++; if (m_awaddr !== 32'h0) begin n_err++; $display("FAIL rst_awaddr got %h want 0", m_awaddr); end
    n_vec++; if (m_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h want 0", m_wdata); end
    n_vec++; if (m_wstrb !== 4'h0) begin n_err++; $display("FAIL rst_wstrb got %h want 0", m_wstrb); end
    n_vec++; if (m_awprot !== 3'b000) begin n_err++; $display("FAIL rst_awprot got %b want 000", m_awprot); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b want 0", timeout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (wr_count !== 16'h0) begin n_err++; $display("FAIL rst_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_key_words();
    logic [31:0] key [4];
    bit acc;
    key[0] = 32'h9D79B1A3; key[1] = 32'h7F31801C; key[2] = 32'hD11A6706; key[3] = 32'hFB40D6BD;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push_cmd(ASCON_BASE + OFS_KEY, key[i], 4'hF, 1, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL key_push%0d got %b want 1", i, acc); end
    end
    wait_wr(exp_count + 4, 100);
    exp_count += 4;
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL key_count got %0d want %0d", wr_count, exp_count); end
    n_vec++; if (aw_log.size() != 4 || wd_log.size() != 4) begin n_err++; $display("FAIL key_nwrites got %0d/%0d want 4", aw_log.size(), wd_log.size()); end
    for (int i = 0; i < 4 && i < aw_log.size() && i < wd_log.size(); i++) begin
      n_vec++;
      if (aw_log[i] !== 32'h0010_0005 || wd_log[i] !== key[i] || ws_log[i] !== 4'hF) begin
        n_err++; $display("FAIL key_word%0d got %h/%h/%h want 00100005/%h/f", i, aw_log[i], wd_log[i], ws_log[i], key[i]);
      end
    end
    for (int i = 1; i < aw_cyc.size(); i++) begin
      n_vec++; if (aw_cyc[i] - aw_cyc[i-1] != 3) begin n_err++; $display("FAIL key_spacing%0d got %0d want 3", i, aw_cyc[i] - aw_cyc[i-1]); end
    end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL key_err got %b want 0", err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL key_busy_end got %b want 0", busy); end
  endtask

  task automatic test_aw_stall();
    bit acc;
    int aw_hi = 0, w_hi = 0, bad_addr = 0, overlap = 0, last_aw = -1, first_b = -1;
    clear_logs();
    aw_stall = 5;
    push_cmd(ASCON_BASE + OFS_NONCE, 32'h57526846, 4'hF, 1, acc);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy got %b want 1", busy); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_awvalid) begin aw_hi++; last_aw = i; if (m_awaddr !== 32'h0010_0000) bad_addr++; end
      if (m_wvalid) w_hi++;
      if (m_bready && m_awvalid) overlap++;
      if (m_bready && first_b < 0) first_b = i;
    end
    step(1);
    aw_stall = 0;
    exp_count++;
    n_vec++; if (aw_hi != 6) begin n_err++; $display("FAIL stall_aw_cycles got %0d want 6", aw_hi); end
    n_vec++; if (w_hi != 1) begin n_err++; $display("FAIL stall_w_cycles got %0d want 1", w_hi); end
    n_vec++; if (bad_addr != 0) begin n_err++; $display("FAIL stall_addr_stable got %0d want 0", bad_addr); end
    n_vec++; if (overlap != 0 || first_b != last_aw + 1) begin n_err++; $display("FAIL stall_bready got first %0d want %0d", first_b, last_aw + 1); end
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL stall_count got %0d want %0d", wr_count, exp_count); end
  endtask

  task automatic test_fifo_full();
    bit acc;
    logic [31:0] d;
    clear_logs();
    aw_block = 1;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      push_cmd(ASCON_BASE + OFS_PT, d, 4'($urandom_range(1, 15)), 1, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL full_push%0d got %b want 1", i, acc); end
    end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", cmd_ready); end
    n_vec++; if (m_awvalid !== 1'b1 || m_awaddr !== exp_q[0].addr) begin n_err++; $display("FAIL full_head got %b/%h want 1/%h", m_awvalid, m_awaddr, exp_q[0].addr); end
    push_cmd(ASCON_BASE + OFS_PT, 32'hDEAD_BEEF, 4'hF, 2, acc);
    n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL full_refuse got %b want 0", acc); end
    aw_block = 0;
    wait_wr(exp_count + 5, 100);
    exp_count += 5;
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL full_count got %0d want %0d", wr_count, exp_count); end
    n_vec++; if (aw_log.size() != 5 || wd_log.size() != 5) begin n_err++; $display("FAIL full_nwrites got %0d/%0d want 5", aw_log.size(), wd_log.size()); end
    for (int i = 0; i < 5 && i < aw_log.size() && i < wd_log.size(); i++) begin
      n_vec++;
      if (aw_log[i] !== exp_q[i].addr || wd_log[i] !== exp_q[i].data || ws_log[i] !== exp_q[i].strb) begin
        n_err++; $display("FAIL full_word%0d got %h/%h want %h/%h", i, aw_log[i], wd_log[i], exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_bresp_err();
    bit acc;
    clear_logs();
    bresp_cfg = RESP_SLVERR;
    push_cmd(ASCON_BASE + OFS_AD, 32'h1AB3C589, 4'hF, 1, acc);
    wait_wr(exp_count + 1, 50);
    exp_count++;
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL slverr_count got %0d want %0d", wr_count, exp_count); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL slverr_err got %b want 1", err); end
    err_clr = 1; step(1); err_clr = 0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL slverr_clear got %b want 0", err); end
    push_cmd(ASCON_BASE + OFS_AD, $urandom, 4'hF, 1, acc);
    for (int i = 0; i < 20 && !m_bready; i++) step(1);
    err_clr = 1; step(1); err_clr = 0;
    exp_count++;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL set_beats_clear got %b want 1", err); end
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL slverr_count2 got %0d want %0d", wr_count, exp_count); end
    bresp_cfg = RESP_OKAY;
    err_clr = 1; step(1); err_clr = 0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL slverr_clear2 got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    clear_logs();
    aw_block = 1; w_block = 1;
    for (int i = 0; i < 3; i++) push_cmd(ASCON_BASE + OFS_AD, $urandom, 4'hF, 1, acc);
    step(1);
    n_vec++; if (m_awvalid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b/%b want 1/1", m_awvalid, busy); end
    #3 rst_n = 0;
    #1;
    n_vec++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0 || busy !== 1'b0 ||
        cmd_ready !== 1'b1 || m_awaddr !== 32'h0 || wr_count !== 16'h0) begin
      n_err++; $display("FAIL rmid_async got aw%b w%b b%b busy%b rdy%b addr%h cnt%0d want all reset", m_awvalid, m_wvalid, m_bready, busy, cmd_ready, m_awaddr, wr_count);
    end
    step(2);
    rst_n = 1; aw_block = 0; w_block = 0;
    clear_logs();
    exp_count = 0;
    step(20);
    n_vec++; if (aw_log.size() != 0 || wd_log.size() != 0) begin n_err++; $display("FAIL rmid_no_write got %0d/%0d want 0", aw_log.size(), wd_log.size()); end
    n_vec++; if (wr_count !== 16'h0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle got %0d/%b want 0/0", wr_count, busy); end
  endtask

  task automatic test_random();
    bit acc;
    logic [31:0] ofs [4];
    int n = 16;
    ofs[0] = OFS_NONCE; ofs[1] = OFS_AD; ofs[2] = OFS_PT; ofs[3] = OFS_KEY;
    clear_logs();
    rand_mode = 1;
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 2));
      push_cmd(ASCON_BASE + ofs[$urandom_range(0, 3)], $urandom, 4'($urandom_range(0, 15)), 100, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rand_push%0d got %b want 1", i, acc); end
    end
    wait_wr(exp_count + n, 2000);
    exp_count += n;
    rand_mode = 0;
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL rand_count got %0d want %0d", wr_count, exp_count); end
    n_vec++; if (aw_log.size() != exp_q.size() || wd_log.size() != exp_q.size()) begin n_err++; $display("FAIL rand_nwrites got %0d/%0d want %0d", aw_log.size(), wd_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < aw_log.size() && i < wd_log.size(); i++) begin
      n_vec++;
      if (aw_log[i] !== exp_q[i].addr || wd_log[i] !== exp_q[i].data || ws_log[i] !== exp_q[i].strb) begin
        n_err++; $display("FAIL rand_word%0d got %h/%h/%h want %h/%h/%h", i, aw_log[i], wd_log[i], ws_log[i], exp_q[i].addr, exp_q[i].data, exp_q[i].strb);
      end
    end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rand_err got %b want 0", err); end
    n_vec++; if (stab_viol != 0) begin n_err++; $display("FAIL stability got %0d want 0", stab_viol); end
  endtask

`ifdef ASCON_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    bit acc;
    int n = 0;
    clear_logs();
    b_never = 1;
    push_cmd(ASCON_BASE + OFS_AD, $urandom, 4'hF, 1, acc);
    push_cmd(ASCON_BASE + OFS_PT, 32'h4FCF816F, 4'hF, 1, acc);
    for (int i = 0; i < 20 && !m_bready; i++) step(1);
    for (int i = 0; i < 20 && !timeout; i++) begin step(1); n++; end
    n_vec++; if (n != 8 || timeout !== 1'b1) begin n_err++; $display("FAIL tmo_latency got %0d want 8", n); end
    n_vec++; if (err !== 1'b1 || m_bready !== 1'b0) begin n_err++; $display("FAIL tmo_flags got err%b bready%b want 1/0", err, m_bready); end
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL tmo_count got %0d want %0d", wr_count, exp_count); end
    b_never = 0;
    wait_wr(exp_count + 1, 50);
    exp_count++;
    n_vec++; if (wr_count !== 16'(exp_count)) begin n_err++; $display("FAIL tmo_next_count got %0d want %0d", wr_count, exp_count); end
    n_vec++; if (aw_log.size() != 2 || aw_log[1] !== 32'h0010_0002 || wd_log[1] !== 32'h4FCF816F) begin n_err++; $display("FAIL tmo_next_word got %0d writes want 2 ending 00100002/4fcf816f", aw_log.size()); end
    err_clr = 1; step(1); err_clr = 0;
    n_vec++; if (timeout !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL tmo_clear got %b/%b want 0/0", timeout, err); end
  endtask
`endif

  initial begin
    test_reset();
    test_key_words();
    test_aw_stall();
    test_fifo_full();
    test_bresp_err();
    test_reset_mid();
    test_random();
`ifdef ASCON_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_axil_feeder.md
# ascon_axil_feeder

AXI4-Lite write master that sits directly upstream of the bus crossbar and the `ascon_wrapper` slave. It replaces hand-driven AW/W/B sequencing. A producer (core-side glue or a DMA) pushes {address, data, strobe} words into a small command FIFO. The block then issues one fully-handshaked AXI4-Lite write per word, in order, and reports completion count and response errors.

## Interface
Parameters:
- `FifoDepth`, 4, command FIFO entries; power of two, ≥2
- `AddrWidth`, 32, AXI address width
- `DataWidth`, 32, AXI data width; strobe width is `DataWidth/8`
- `TimeoutCycles`, 256, watchdog limit; used only with the timeout macro

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command push handshake.
- `cmd_addr_i` in AddrWidth, `cmd_data_i` in DataWidth, `cmd_strb_i` in DataWidth/8: command payload.
- `m_awvalid_o` out 1, `m_awready_i` in 1, `m_awaddr_o` out AddrWidth, `m_awprot_o` out 3: AXI write-address channel.
- `m_wvalid_o` out 1, `m_wready_i` in 1, `m_wdata_o` out DataWidth, `m_wstrb_o` out DataWidth/8: AXI write-data channel.
- `m_bvalid_i` in 1, `m_bready_o` out 1, `m_bresp_i` in 2: AXI write-response channel.
- `busy_o` out 1: FIFO non-empty or FSM not IDLE.
- `err_o` out 1: sticky; any non-OKAY response or timeout.
- `err_clr_i` in 1: clears `err_o` and `timeout_o`.
- `timeout_o` out 1: sticky watchdog flag.
- `wr_count_o` out 16: completed B handshakes, wrapping.

## Operation
- FIFO push on `cmd_valid_i && cmd_ready_o`. `cmd_ready_o = !full` is registered-state only; there is no bypass. Order is preserved.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, pop the head into the output registers, raise `m_awvalid_o` and `m_wvalid_o`, and go to ADDR.
  - ADDR:
    - AW and W complete independently.
    - Each valid drops on the cycle after its own handshake. Per-channel done flags are tracked.
    - When both channels are done (including same-cycle), raise `m_bready_o` and go to RESP.
    - Address and data stay stable while their valid is high.
  - RESP:
    - On `m_bvalid_i && m_bready_o`: drop `m_bready_o`, increment `wr_count_o`, and return to IDLE.
    - If `m_bresp_i != 2'b00`, also set `err_o`.
- `m_awprot_o` is constant `3'b000`.
- `wr_count_o` wraps 0xFFFF→0x0000.
- Boundary cases:
  - If `err_o` set and `err_clr_i` occur in the same cycle, set wins.
  - Full FIFO: `cmd_ready_o` is 0 and the push is refused. A pop and a refused push in the same cycle leave the FIFO with FifoDepth-1 entries.
  - Pushing into an empty FIFO while in IDLE: the pop happens on the following edge, never the same cycle.
  - Reset mid-transaction: the transaction is abandoned and the FIFO is emptied. The bus shares `rst_ni`, so no orphan handshake survives.

## Timing
- Reset values:
  - all valid/ready outputs 0
  - `cmd_ready_o` 1
  - addr/data/strb 0
  - `err_o`, `timeout_o`, `busy_o` 0
  - `wr_count_o` 0
  - FSM IDLE
- Push at edge k → `m_awvalid_o`/`m_wvalid_o` high after edge k+1.
- With a zero-wait slave (ready and bvalid combinationally available), each write takes 3 cycles: IDLE, ADDR, RESP. Peak throughput is 1 write per 3 cycles.
- `busy_o` is high from the cycle after the first push until the cycle after the last B handshake.

## Configuration
`ASCON_FEEDER_TIMEOUT_EN`:
- **Defined:**
  - A counter runs in ADDR/RESP and resets on each state entry.
  - On reaching `TimeoutCycles`, all AXI valids and `m_bready_o` drop, `timeout_o` and `err_o` are set, `wr_count_o` is not incremented, and the FSM returns to IDLE.
  - The next FIFO entry then proceeds.
- **Undefined:** the block waits indefinitely. `timeout_o` is tied 0. The port exists in both builds.

## Structure
- Package `ascon_feeder_pkg`:
  - state enum `{IDLE, ADDR, RESP}`
  - AXI resp constants: OKAY=0, SLVERR=2
  - Ascon map constants: base 32'h100000; offsets NONCE=0x0, AD=0x1, PT=0x2, KEY=0x5
- Sub-module `ascon_feeder_fifo`: synchronous FIFO with pointer-plus-wrap-bit full/empty and async active-low reset.

## Test plan
- Push the 4 key words to 0x100005 (9D79B1A3, 7F31801C, D11A6706, FB40D6BD) with an always-ready slave → 4 AW/W pairs in order with strb 4'hF, `wr_count_o`=4, `err_o`=0.
- Slave holds `m_awready_i` low 5 cycles but accepts W immediately (nonce 57526846 @0x100000):
  - `m_wvalid_o` drops after 1 cycle
  - `m_awvalid_o` stays high with a stable address
  - `m_bready_o` rises only after the AW handshake
- Push 5 words with `m_awready_i` stuck low and FifoDepth=4:
  - the first word is popped
  - the FIFO fills after 4 more pushes
  - `cmd_ready_o`=0
  - the 6th push is refused
- Slave returns `m_bresp_i`=2'b10 on AD word 1AB3C589 @0x100001:
  - `err_o`=1 and `wr_count_o` increments
  - pulse `err_clr_i` → `err_o`=0
  - same-cycle error and clear → `err_o`=1
- Assert `rst_ni`=0 while in ADDR with 2 queued words:
  - all outputs return to reset values asynchronously
  - after release, no write is issued
- With `ASCON_FEEDER_TIMEOUT_EN`, TimeoutCycles=8, and `m_bvalid_i` never asserted:
  - `timeout_o` and `err_o` are set 8 cycles after RESP entry
  - the next queued word (plaintext 4FCF816F @0x100002) is then issued
